// File: rtl/rnn_cell_engine.sv
// rnn_cell_engine: Elman-RNN sequencer over a shared single-port memory, h_t[j] = act(W x + b_x + U h + b_h).
// Latency: 2-cycle T fetch, then HID*(IN_BITS+3)+1 cycles for t=0 and HID*(IN_BITS+HID+3)+1 per later step.
// No backpressure: ready is ignored while busy. Build macro RNN_RELU_EN selects a [0,+1.0] clamp over [-1.0,+1.0].
module rnn_cell_engine #(
  parameter int HID     = 64,
  parameter int IN_BITS = 32,
  parameter int DW      = 20,
  parameter int FRAC    = 16,
  parameter int TW      = 11,
  parameter int AW      = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  output logic               busy,
  output logic               i_en,
  input  logic [IN_BITS-1:0] idata,
  input  logic [DW-1:0]      mdata_r,
  output logic [DW-1:0]      mdata_w,
  output logic               mce,
  output logic [AW-1:0]      maddr,
  output logic [2:0]         msel
);
  localparam int HB = $clog2(HID);
  localparam int KB = $clog2(IN_BITS);
  localparam int CW = (HB > KB) ? HB : KB;
  localparam int AB = 2*DW + $clog2(HID+IN_BITS+2);

  localparam logic signed [AB-1:0] C_ONE  = {{(AB-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [AB-1:0] C_HALF = {{(AB-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`ifdef RNN_RELU_EN
  localparam logic signed [AB-1:0] C_LO   = '0;
`else
  localparam logic signed [AB-1:0] C_LO   = -C_ONE;
`endif

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P_W    = 2'd1;
  localparam logic [1:0] P_B    = 2'd2;
  localparam logic [1:0] P_U    = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_LD_T, S_LD_W, S_WX, S_BX, S_UH, S_BH, S_WR, S_SWAP, S_DONE
  } state_t;

  state_t                r_state, w_next;
  logic [HB-1:0]         r_j;
  logic [CW-1:0]         r_cnt;
  logic [TW-1:0]         r_t, r_tmax;
  logic [IN_BITS-1:0]    r_x;
  logic [1:0]            r_p_op;
  logic [CW-1:0]         r_p_idx;
  logic signed [AB-1:0]  r_acc;
  logic signed [DW-1:0]  r_h_old [HID];
  logic signed [DW-1:0]  r_h_new [HID];

  logic                  w_last_k, w_last_i, w_last_j, w_last_t;
  logic signed [DW-1:0]  w_hsel;
  logic signed [2*DW-1:0] w_prod;
  logic signed [AB-1:0]  w_bias, w_add, w_sum, w_q;
  logic signed [DW-1:0]  w_act;

  assign w_last_k = (r_cnt == CW'(IN_BITS-1));
  assign w_last_i = (r_cnt == CW'(HID-1));
  assign w_last_j = (r_j == HB'(HID-1));
  assign w_last_t = (r_t == r_tmax - TW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (ready) w_next = S_LD_T;
      S_LD_T: w_next = S_LD_W;
      S_LD_W: w_next = (mdata_r[TW-1:0] == '0) ? S_DONE : S_WX;
      S_WX:   if (w_last_k) w_next = S_BX;
      S_BX:   w_next = (r_t == '0) ? S_BH : S_UH;
      S_UH:   if (w_last_i) w_next = S_BH;
      S_BH:   w_next = S_WR;
      S_WR: begin
        if (!w_last_j)     w_next = S_WX;
        else if (w_last_t) w_next = S_DONE;
        else               w_next = S_SWAP;
      end
      S_SWAP: w_next = S_WX;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    i_en    = 1'b0;
    msel    = 3'd0;
    maddr   = '0;
    mdata_w = '0;
    case (r_state)
      S_LD_T: begin
        msel = 3'd4;
        i_en = 1'b1;
      end
      S_LD_W: msel = 3'd4;
      S_WX:   maddr = AW'({r_j, r_cnt[KB-1:0]});
      S_BX: begin
        msel  = 3'd1;
        maddr = AW'(r_j);
      end
      S_UH: begin
        msel  = 3'd2;
        maddr = AW'({r_j, r_cnt[HB-1:0]});
      end
      S_BH: begin
        msel  = 3'd3;
        maddr = AW'(r_j);
      end
      S_WR: begin
        msel    = 3'd5;
        maddr   = AW'({r_t, r_j});
        mdata_w = w_act;
      end
      S_SWAP: i_en = 1'b1;
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign mce  = busy;

  // Read data is tagged with the operand kind issued one cycle earlier.
  assign w_hsel = r_h_old[r_p_idx[HB-1:0]];
  assign w_prod = $signed(mdata_r) * w_hsel;
  assign w_bias = {{(AB-DW-FRAC){mdata_r[DW-1]}}, mdata_r, {FRAC{1'b0}}};

  always_comb begin
    w_add = '0;
    case (r_p_op)
      P_W: if (r_x[r_p_idx[KB-1:0]]) w_add = w_bias;
      P_B: w_add = w_bias;
      P_U: w_add = {{(AB-2*DW){w_prod[2*DW-1]}}, w_prod};
      default: ;
    endcase
  end

  assign w_sum = r_acc + w_add;
  assign w_q   = (w_sum + C_HALF) >>> FRAC;

  always_comb begin
    if (w_q > C_ONE)     w_act = C_ONE[DW-1:0];
    else if (w_q < C_LO) w_act = C_LO[DW-1:0];
    else                 w_act = w_q[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_j     <= '0;
      r_cnt   <= '0;
      r_t     <= '0;
      r_tmax  <= '0;
      r_x     <= '0;
      r_p_op  <= P_NONE;
      r_p_idx <= '0;
      r_acc   <= '0;
      for (int n = 0; n < HID; n++) begin
        r_h_old[n] <= '0;
        r_h_new[n] <= '0;
      end
    end else begin
      r_p_op  <= P_NONE;
      r_p_idx <= r_cnt;
      r_acc   <= w_sum;
      case (r_state)
        S_IDLE: begin
          r_acc <= '0;
          r_j   <= '0;
          r_cnt <= '0;
          r_t   <= '0;
        end
        S_LD_T: begin
          r_x <= idata;
          for (int n = 0; n < HID; n++) r_h_old[n] <= '0;
        end
        S_LD_W: r_tmax <= mdata_r[TW-1:0];
        S_WX: begin
          r_p_op <= P_W;
          r_cnt  <= w_last_k ? '0 : r_cnt + CW'(1);
        end
        S_BX: r_p_op <= P_B;
        S_UH: begin
          r_p_op <= P_U;
          r_cnt  <= w_last_i ? '0 : r_cnt + CW'(1);
        end
        S_BH: r_p_op <= P_B;
        S_WR: begin
          r_acc        <= '0;
          r_h_new[r_j] <= w_act;
          r_j          <= r_j + HB'(1);
        end
        S_SWAP: begin
          r_h_old <= r_h_new;
          r_t     <= r_t + TW'(1);
          r_x     <= idata;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rnn_cell_engine.sv
// Directed bench: a 4x4 instance for hand-computed cases, a default 64x32 instance against a golden model.
module tb_rnn_cell_engine;
  localparam int DW = 20;
  localparam int AW = 17;
  localparam int BIG_CYC = 2 + (64*35+1) + 2*(64*99+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic          s_ready, s_busy, s_i_en, s_mce;
  logic [3:0]    s_idata;
  logic [DW-1:0] s_mdr, s_mdw;
  logic [AW-1:0] s_maddr;
  logic [2:0]    s_msel;

  logic          b_ready, b_busy, b_i_en, b_mce;
  logic [31:0]   b_idata;
  logic [DW-1:0] b_mdr, b_mdw;
  logic [AW-1:0] b_maddr;
  logic [2:0]    b_msel;

  rnn_cell_engine #(.HID(4), .IN_BITS(4)) u_small (
    .clk(clk), .reset(reset), .ready(s_ready), .busy(s_busy), .i_en(s_i_en),
    .idata(s_idata), .mdata_r(s_mdr), .mdata_w(s_mdw), .mce(s_mce),
    .maddr(s_maddr), .msel(s_msel));

  rnn_cell_engine u_big (
    .clk(clk), .reset(reset), .ready(b_ready), .busy(b_busy), .i_en(b_i_en),
    .idata(b_idata), .mdata_r(b_mdr), .mdata_w(b_mdw), .mce(b_mce),
    .maddr(b_maddr), .msel(b_msel));

  logic [DW-1:0] s_w [16];
  logic [DW-1:0] s_u [16];
  logic [DW-1:0] s_bx [4];
  logic [DW-1:0] s_bh [4];
  logic [DW-1:0] s_tval;
  logic [3:0]    s_x [8];
  logic [2:0]    s_xi = '0;
  int            s_wr_cnt = 0;
  logic [AW-1:0] s_wa [64];
  logic [DW-1:0] s_wd [64];

  assign s_idata = s_x[s_xi];

  always @(posedge clk) begin
    if (s_ready && !s_busy) s_xi <= '0;
    else if (s_i_en)        s_xi <= s_xi + 3'd1;
    if (s_mce) begin
      case (s_msel)
        3'd0: s_mdr <= s_w[s_maddr[3:0]];
        3'd1: s_mdr <= s_bx[s_maddr[1:0]];
        3'd2: s_mdr <= s_u[s_maddr[3:0]];
        3'd3: s_mdr <= s_bh[s_maddr[1:0]];
        3'd4: s_mdr <= s_tval;
        3'd5: begin
          s_wa[s_wr_cnt[5:0]] <= s_maddr;
          s_wd[s_wr_cnt[5:0]] <= s_mdw;
          s_wr_cnt <= s_wr_cnt + 1;
        end
        default: s_mdr <= 'x;
      endcase
    end
  end

  logic [DW-1:0] b_w [2048];
  logic [DW-1:0] b_u [4096];
  logic [DW-1:0] b_bx [64];
  logic [DW-1:0] b_bh [64];
  logic [DW-1:0] b_tval;
  logic [31:0]   b_x [4];
  logic [1:0]    b_xi = '0;
  int            b_wr_cnt = 0;
  logic [DW-1:0] b_h [256];

  assign b_idata = b_x[b_xi];

  always @(posedge clk) begin
    if (b_ready && !b_busy) b_xi <= '0;
    else if (b_i_en)        b_xi <= b_xi + 2'd1;
    if (b_mce) begin
      case (b_msel)
        3'd0: b_mdr <= b_w[b_maddr[10:0]];
        3'd1: b_mdr <= b_bx[b_maddr[5:0]];
        3'd2: b_mdr <= b_u[b_maddr[11:0]];
        3'd3: b_mdr <= b_bh[b_maddr[5:0]];
        3'd4: b_mdr <= b_tval;
        3'd5: begin
          b_h[b_maddr[7:0]] <= b_mdw;
          b_wr_cnt <= b_wr_cnt + 1;
        end
        default: b_mdr <= 'x;
      endcase
    end
  end

  task automatic clear_s;
    for (int n = 0; n < 16; n++) begin
      s_w[n] = '0;
      s_u[n] = '0;
    end
    for (int n = 0; n < 4; n++) begin
      s_bx[n] = '0;
      s_bh[n] = '0;
    end
    for (int n = 0; n < 8; n++) s_x[n] = '0;
    s_tval = '0;
  endtask

  // Pulses ready for one cycle and counts cycles with busy high; ends on a falling edge.
  task automatic run_s(input int max_cyc, output int ncyc);
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    ncyc = 0;
    while (s_busy && ncyc < max_cyc) begin
      ncyc++;
      @(negedge clk);
    end
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL run_timeout: busy=%b after %0d cycles, required 0", s_busy, ncyc);
    end
  endtask

  task automatic setup_recur;
    clear_s;
    s_tval = 20'd2;
    for (int j = 0; j < 4; j++) begin
      s_w[j*4+j] = 20'h08000;
      s_u[j*4+j] = 20'h10000;
    end
    s_x[0] = 4'b1111;
    s_x[1] = 4'b0000;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    s_ready = 1'b0;
    b_ready = 1'b0;
    #12;
    checks++; if (s_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b, expected 0", s_busy); end
    checks++; if (s_i_en !== 1'b0)  begin errors++; $display("FAIL reset_i_en: got %b, expected 0", s_i_en); end
    checks++; if (s_mce !== 1'b0)   begin errors++; $display("FAIL reset_mce: got %b, expected 0", s_mce); end
    checks++; if (s_maddr !== '0)   begin errors++; $display("FAIL reset_maddr: got %h, expected 0", s_maddr); end
    checks++; if (s_msel !== 3'd0)  begin errors++; $display("FAIL reset_msel: got %0d, expected 0", s_msel); end
    checks++; if (s_mdw !== '0)     begin errors++; $display("FAIL reset_mdata_w: got %h, expected 0", s_mdw); end
    checks++; if (b_busy !== 1'b0)  begin errors++; $display("FAIL reset_big_busy: got %b, expected 0", b_busy); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_step;
    int n, base, e;
    clear_s;
    s_tval = 20'd1;
    for (int m = 0; m < 16; m++) s_w[m] = 20'h01000;
    s_x[0] = 4'b1010;
    base = s_wr_cnt;
    run_s(200, n);
    checks++;
    if (n !== 31) begin errors++; $display("FAIL step_cycles: got %0d busy cycles, expected 31", n); end
    checks++;
    if (s_wr_cnt - base !== 4) begin errors++; $display("FAIL step_writes: got %0d writes, expected 4", s_wr_cnt - base); end
    for (int j = 0; j < 4; j++) begin
      e = (base + j) % 64;
      checks++;
      if (s_wa[e] !== AW'(j) || s_wd[e] !== 20'h02000) begin
        errors++;
        $display("FAIL step_h%0d: got addr %0d data %h, expected addr %0d data 02000", j, s_wa[e], s_wd[e], j);
      end
    end
  endtask

  task automatic test_recurrence;
    int n, base, e;
    setup_recur;
    base = s_wr_cnt;
    run_s(300, n);
    checks++;
    if (n !== 76) begin errors++; $display("FAIL recur_cycles: got %0d busy cycles, expected 76", n); end
    checks++;
    if (s_wr_cnt - base !== 8) begin errors++; $display("FAIL recur_writes: got %0d writes, expected 8", s_wr_cnt - base); end
    for (int m = 0; m < 8; m++) begin
      e = (base + m) % 64;
      checks++;
      if (s_wa[e] !== AW'(m) || s_wd[e] !== 20'h08000) begin
        errors++;
        $display("FAIL recur_w%0d: got addr %0d data %h, expected addr %0d data 08000", m, s_wa[e], s_wd[e], m);
      end
    end
  endtask

  task automatic test_saturation;
    int n, base, e;
    logic [DW-1:0] exp_neg;
`ifdef RNN_RELU_EN
    exp_neg = 20'h00000;
`else
    exp_neg = 20'hF0000;
`endif
    clear_s;
    s_tval = 20'd1;
    for (int j = 0; j < 4; j++) s_bx[j] = 20'h30000;
    base = s_wr_cnt;
    run_s(200, n);
    for (int j = 0; j < 4; j++) begin
      e = (base + j) % 64;
      checks++;
      if (s_wd[e] !== 20'h10000) begin errors++; $display("FAIL sat_pos_h%0d: got %h, expected 10000", j, s_wd[e]); end
    end
    for (int j = 0; j < 4; j++) s_bx[j] = 20'hD0000;
    base = s_wr_cnt;
    run_s(200, n);
    for (int j = 0; j < 4; j++) begin
      e = (base + j) % 64;
      checks++;
      if (s_wd[e] !== exp_neg) begin errors++; $display("FAIL sat_neg_h%0d: got %h, expected %h", j, s_wd[e], exp_neg); end
    end
  endtask

  task automatic test_rounding;
    int n, base, e;
    logic [DW-1:0] exp_r [4];
`ifdef RNN_RELU_EN
    exp_r = '{20'h00001, 20'h00000, 20'h00002, 20'h00000};
`else
    exp_r = '{20'h00001, 20'h00000, 20'h00002, 20'hFFFFF};
`endif
    clear_s;
    s_tval = 20'd2;
    for (int j = 0; j < 4; j++) s_w[j*4+j] = 20'h08000;
    s_x[0] = 4'b1111;
    s_u[0]  = 20'h00001;
    s_u[5]  = 20'hFFFFF;
    s_u[10] = 20'h00003;
    s_u[15] = 20'hFFFFD;
    base = s_wr_cnt;
    run_s(300, n);
    for (int j = 0; j < 4; j++) begin
      e = (base + 4 + j) % 64;
      checks++;
      if (s_wd[e] !== exp_r[j]) begin errors++; $display("FAIL round_h%0d: got %h, expected %h", j, s_wd[e], exp_r[j]); end
    end
  endtask

  task automatic test_zero_t;
    int nb, starts, n5, base;
    logic prev;
    clear_s;
    s_tval = 20'd0;
    base = s_wr_cnt;
    nb = 0; starts = 0; n5 = 0; prev = 1'b0;
    s_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (s_busy) nb++;
      if (s_busy && !prev) starts++;
      if (s_msel == 3'd5) n5++;
      if (!s_busy && prev) s_ready = 1'b0;
      prev = s_busy;
    end
    s_ready = 1'b0;
    checks++;
    if (nb !== 3) begin errors++; $display("FAIL zero_t_busy: got %0d busy cycles, expected 3", nb); end
    checks++;
    if (starts !== 1) begin errors++; $display("FAIL zero_t_starts: got %0d runs, expected 1", starts); end
    checks++;
    if (n5 !== 0 || s_wr_cnt - base !== 0) begin
      errors++;
      $display("FAIL zero_t_writes: got %0d write cycles / %0d writes, expected 0", n5, s_wr_cnt - base);
    end
  endtask

  task automatic test_abort_restart;
    int c, n, base, e;
    setup_recur;
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    c = 0;
    while (s_msel !== 3'd2 && c < 200) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (s_msel !== 3'd2) begin errors++; $display("FAIL abort_reach_uh: msel=%0d, expected 2", s_msel); end
    #1 reset = 1'b0;
    #1;
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", s_busy); end
    checks++; if (s_mce !== 1'b0)  begin errors++; $display("FAIL abort_mce: got %b, expected 0", s_mce); end
    checks++; if (s_maddr !== '0)  begin errors++; $display("FAIL abort_maddr: got %h, expected 0", s_maddr); end
    checks++; if (s_msel !== 3'd0) begin errors++; $display("FAIL abort_msel: got %0d, expected 0", s_msel); end
    checks++; if (s_mdw !== '0)    begin errors++; $display("FAIL abort_mdata_w: got %h, expected 0", s_mdw); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = s_wr_cnt;
    run_s(300, n);
    checks++;
    if (n !== 76 || s_wr_cnt - base !== 8) begin
      errors++;
      $display("FAIL restart_run: got %0d cycles %0d writes, expected 76 cycles 8 writes", n, s_wr_cnt - base);
    end
    for (int m = 0; m < 8; m++) begin
      e = (base + m) % 64;
      checks++;
      if (s_wa[e] !== AW'(m) || s_wd[e] !== 20'h08000) begin
        errors++;
        $display("FAIL restart_w%0d: got addr %0d data %h, expected addr %0d data 08000", m, s_wa[e], s_wd[e], m);
      end
    end
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [DW-1:0] rnd_val(input int span);
    int v;
    v = int'($urandom_range(0, 2*span)) - span;
    return v[DW-1:0];
  endfunction

  task automatic test_golden;
    longint hold [64];
    longint hnew [64];
    longint acc, q, lo;
    logic [DW-1:0] exp_h [192];
    int n, base;
`ifdef RNN_RELU_EN
    lo = 0;
`else
    lo = -65536;
`endif
    for (int m = 0; m < 2048; m++) b_w[m] = rnd_val(6000);
    for (int m = 0; m < 4096; m++) b_u[m] = rnd_val(6000);
    for (int m = 0; m < 64; m++) begin
      b_bx[m] = rnd_val(12000);
      b_bh[m] = rnd_val(12000);
      hold[m] = 0;
    end
    for (int m = 0; m < 4; m++) b_x[m] = $urandom;
    b_tval = 20'd3;
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < 64; j++) begin
        acc = 0;
        for (int k = 0; k < 32; k++)
          if (b_x[t][k]) acc += sx(b_w[j*32+k]) * 65536;
        acc += sx(b_bx[j]) * 65536;
        if (t > 0)
          for (int i = 0; i < 64; i++) acc += sx(b_u[j*64+i]) * hold[i];
        acc += sx(b_bh[j]) * 65536;
        q = (acc + 32768) >>> 16;
        if (q > 65536) q = 65536;
        if (q < lo) q = lo;
        hnew[j] = q;
        exp_h[t*64+j] = q[DW-1:0];
      end
      for (int j = 0; j < 64; j++) hold[j] = hnew[j];
    end
    base = b_wr_cnt;
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    n = 0;
    while (b_busy && n < 20000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== BIG_CYC) begin errors++; $display("FAIL golden_cycles: got %0d busy cycles, expected %0d", n, BIG_CYC); end
    checks++;
    if (b_wr_cnt - base !== 192) begin errors++; $display("FAIL golden_writes: got %0d writes, expected 192", b_wr_cnt - base); end
    for (int a = 0; a < 192; a++) begin
      checks++;
      if (b_h[a] !== exp_h[a]) begin
        errors++;
        $display("FAIL golden_h t=%0d j=%0d: got %h, expected %h", a / 64, a % 64, b_h[a], exp_h[a]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_single_step;
    test_recurrence;
    test_saturation;
    test_rounding;
    test_zero_t;
    test_abort_restart;
    test_golden;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
